// File: rtl/maxpool2_unit.sv
// -----------------------------------------------------------------------------
// maxpool2_unit
//
// 2x2, stride-2 max-pooling stage placed after conv2. For each of the CH input
// maps (IN_DIM x IN_DIM) it produces one OUT_DIM x OUT_DIM pooled map. Every
// output is built one input element per cycle: four ACC cycles keep a running
// signed maximum, then one STORE cycle writes it to the output array. That is
// five cycles per output.
//
// Ports
//   clk        : sole clock, rising edge
//   reset      : synchronous, active-high
//   start      : begin a pass; only looked at while idle
//   conv2_maps : signed 32-bit input maps [CH][IN_DIM][IN_DIM]; the source
//                holds them stable from start until done
//   busy       : high while a pass runs (ACC, STORE and DONE states)
//   done       : set when a pass completes; cleared by the next accepted start
//   pool2_maps : registered signed 32-bit pooled maps [CH][OUT_DIM][OUT_DIM]
// -----------------------------------------------------------------------------
module maxpool2_unit #(
  parameter int CH      = 32,
  parameter int IN_DIM  = 14,
  parameter int OUT_DIM = IN_DIM / 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic signed [31:0] conv2_maps [0:CH-1][0:IN_DIM-1][0:IN_DIM-1],
  output logic               busy,
  output logic               done,
  output logic signed [31:0] pool2_maps [0:CH-1][0:OUT_DIM-1][0:OUT_DIM-1]
);

  localparam int FW = (CH > 1)      ? $clog2(CH)      : 1;
  localparam int IW = (OUT_DIM > 1) ? $clog2(OUT_DIM) : 1;

  localparam logic [FW-1:0] LAST_F = FW'(CH - 1);
  localparam logic [IW-1:0] LAST_IJ = IW'(OUT_DIM - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACC,
    S_STORE,
    S_DONE
  } state_t;

  state_t               r_state;
  logic [FW-1:0]        r_f;
  logic [IW-1:0]        r_i;
  logic [IW-1:0]        r_j;
  logic [1:0]           r_k;
  logic signed [31:0]   r_run_max;

  // Window element k lives at (2i + k[1], 2j + k[0]); since IN_DIM = 2*OUT_DIM
  // the doubled coordinate is just the counter with the k bit appended.
  logic [IW:0]          w_row;
  logic [IW:0]          w_col;
  logic signed [31:0]   w_elem;

  assign w_row  = {r_i, r_k[1]};
  assign w_col  = {r_j, r_k[0]};
  assign w_elem = conv2_maps[r_f][w_row][w_col];

  // NOTE: all state here is updated with non-blocking assignments so every
  // register samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      r_f       <= '0;
      r_i       <= '0;
      r_j       <= '0;
      r_k       <= '0;
      r_run_max <= '0;
      // NOTE: the pooled outputs must read as zero after reset, so this array
      // is plain flops cleared by a loop; a RAM macro could not offer that.
      for (int f = 0; f < CH; f++) begin
        for (int i = 0; i < OUT_DIM; i++) begin
          for (int j = 0; j < OUT_DIM; j++) begin
            pool2_maps[f][i][j] <= '0;
          end
        end
      end
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_f     <= '0;
            r_i     <= '0;
            r_j     <= '0;
            r_k     <= '0;
            done    <= 1'b0;
            busy    <= 1'b1;
            r_state <= S_ACC;
          end
        end

        S_ACC: begin
          // k=0 seeds the maximum with the first element so that windows
          // containing only negative values pool correctly.
          if (r_k == 2'd0 || w_elem > r_run_max) begin
            r_run_max <= w_elem;
          end
          r_k <= r_k + 2'd1;
          if (r_k == 2'd3) begin
            r_state <= S_STORE;
          end
        end

        S_STORE: begin
          pool2_maps[r_f][r_i][r_j] <= r_run_max;
          r_k     <= '0;
          r_state <= S_ACC;
          // Row-major walk: j fastest, then i, then f.
          if (r_j == LAST_IJ) begin
            r_j <= '0;
            if (r_i == LAST_IJ) begin
              r_i <= '0;
              if (r_f == LAST_F) begin
                r_f     <= '0;
                r_state <= S_DONE;
              end else begin
                r_f <= r_f + 1'b1;
              end
            end else begin
              r_i <= r_i + 1'b1;
            end
          end else begin
            r_j <= r_j + 1'b1;
          end
        end

        S_DONE: begin
          // start is not looked at here, so a request in this cycle is only
          // taken on the following edge from IDLE.
          done    <= 1'b1;
          busy    <= 1'b0;
          r_state <= S_IDLE;
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/maxpool2_unit.md
# maxpool2_unit

2x2, stride-2 max-pooling stage that sits directly downstream of the second convolution layer. It consumes the 32 ReLU'd 14x14 feature maps produced by conv2 and writes 32 pooled 7x7 maps for the flatten/dense stage. It uses a start/done handshake like its neighbours. Each output is built sequentially: one input element is read per cycle and compared against a running maximum.

## Interface
- CH, 32, number of feature maps
- IN_DIM, 14, input map height/width (must be even)
- OUT_DIM, IN_DIM/2, output map height/width
- clk  input  1  sole clock; all state updates on rising edge
- reset  input  1  synchronous, active-high; sampled on clk rising edge
- start  input  1  begin a pooling pass; sampled only in IDLE
- conv2_maps  input  signed [31:0] [0:CH-1][0:IN_DIM-1][0:IN_DIM-1]  conv2 output maps; must be held stable from start until done
- busy  output  1  high while a pass is in progress (ACC, STORE, DONE states)
- done  output  1  high once a pass completes; held until the next accepted start
- pool2_maps  output  signed [31:0] [0:CH-1][0:OUT_DIM-1][0:OUT_DIM-1]  pooled maps, registered

## Operation
- Internal registers:
  - f, 0..CH-1
  - i and j, 0..OUT_DIM-1
  - k, 0..3
  - run_max, signed 32-bit
- Window element order for output (f,i,j):
  - k=0 reads (2i,2j)
  - k=1 reads (2i,2j+1)
  - k=2 reads (2i+1,2j)
  - k=3 reads (2i+1,2j+1)
- All comparisons are signed 32-bit. There is no saturation and no ReLU; negative inputs must pool correctly. On ties either value is acceptable, since they are equal.
- IDLE
  - start=1: clear f, i, j, k and done, go to ACC.
  - start=0: stay in IDLE.
- ACC
  - k=0: run_max <= element.
  - k>0: run_max <= max(run_max, element).
  - k increments each cycle. After the k=3 cycle, go to STORE.
- STORE
  - pool2_maps[f][i][j] <= run_max; k <= 0.
  - Advance j. On wrap j=OUT_DIM-1 -> 0, advance i. On wrap i=OUT_DIM-1 -> 0, advance f.
  - If (f,i,j) was (CH-1, OUT_DIM-1, OUT_DIM-1), go to DONE; otherwise go to ACC.
- DONE: done <= 1, go to IDLE.
- start asserted while busy is ignored, with no restart and no corruption of the pass.
- start asserted in the same cycle that DONE returns to IDLE is not accepted; it is sampled on the following cycle.
- Re-start after done clears done on the accepting edge and recomputes every output. pool2_maps keeps its old contents until each entry is overwritten.
- Reset
  - Any state goes to IDLE.
  - done=0, busy=0, all counters 0, run_max=0, every pool2_maps entry = 0.
  - Reset mid-pass aborts the pass; done does not assert for it.

## Timing
- Per output: 4 ACC cycles + 1 STORE cycle = 5 cycles.
- Edge 0 is the edge that samples start in IDLE. Output n (0-based, row-major over f, then i, then j) becomes visible after edge 5(n+1).
- Default parameters give 1568 outputs. The last STORE is at edge 7840, the DONE state is at edge 7841, and done=1 after edge 7841.
- busy rises after edge 0 and falls after edge 7841, the same edge where done rises.
- No combinational path from start or conv2_maps to any output.

## Test plan
- Reset values: hold reset 2 cycles with random conv2_maps -> busy=0, done=0, all 1568 pool2_maps = 0. Start asserted during reset is ignored.
- Directed window: all conv2_maps = 0 except map 3 rows 4-5, cols 6-7 = {5, 9, -2, 7} -> pool2_maps[3][2][3] = 9, all others 0. done rises exactly 7841 edges after the start edge.
- Max in each window position:
  - Four maps place the max at k=0, 1, 2 and 3 respectively (value 100, others 1).
  - All-negative window {-8, -3, -5, -20} -> output -3. Checks the signed compare and the k=0 initialisation.
- Full random: conv2_maps random signed 32-bit, including 0x80000000 and 0x7FFFFFFF -> all 1568 outputs match the reference model. Output n is written exactly at edge 5(n+1).
- Start while busy: pulse start at edges 100 and 3000 -> no effect on timing or results.
- Re-run: after done, change inputs and pulse start -> done drops on the accepting edge and the new results are correct.
- Reset at edge 2000 mid-pass -> immediate IDLE, outputs cleared, done stays 0. A following start completes normally in 7841 edges.
